axil_reg_sequencer: RTL and testbench
=====================================

Name: axil_reg_sequencer

Overview:
- AXI4-Lite slave front-end that sequences accesses into the base IP register bank.
- Decouples the AW, W and AR channels, then arbitrates pending writes and reads onto a single-port register-bank interface using round-robin priority.
- Generates the B and R responses, including SLVERR for out-of-range word addresses.
- Sits between the PS interconnect (S_AXI) and the LED/switch/button/UART/IRQ register file.

Parameters:
- P_ADDR_WIDTH, 8, byte address width of S_AXI.
- P_DATA_WIDTH, 32, data width; fixed at 32 for AXI4-Lite.
- P_NUM_REGS, 16, number of implemented 32-bit registers; word index >= P_NUM_REGS decodes as error.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset; asynchronous assert, active-low, one clock domain.
- s_awvalid / s_awready  in / out  1 / 1  AW handshake.
- s_awaddr  in  P_ADDR_WIDTH  write byte address.
- s_awprot  in  3  ignored.
- s_wvalid / s_wready  in / out  1 / 1  W handshake.
- s_wdata  in  P_DATA_WIDTH  write data.
- s_wstrb  in  P_DATA_WIDTH/8  byte strobes.
- s_bvalid / s_bready  out / in  1 / 1  B handshake.
- s_bresp  out  2  OKAY or SLVERR.
- s_arvalid / s_arready  in / out  1 / 1  AR handshake.
- s_araddr  in  P_ADDR_WIDTH  read byte address.
- s_arprot  in  3  ignored.
- s_rvalid / s_rready  out / in  1 / 1  R handshake.
- s_rdata  out  P_DATA_WIDTH  read data, registered.
- s_rresp  out  2  OKAY or SLVERR.
- reg_wr_en  out  1  one-cycle write strobe to the register bank.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_addr  out  P_ADDR_WIDTH-2  word index, shared by reads and writes.
- reg_wdata  out  P_DATA_WIDTH  write data.
- reg_wstrb  out  P_DATA_WIDTH/8  write strobes.
- reg_rdata  in  P_DATA_WIDTH  read data from the bank, valid the cycle after reg_rd_en.

Behaviour:
Reset
- On ARESETN=0, asynchronously and immediately: s_bvalid=0, s_rvalid=0, reg_wr_en=0, reg_rd_en=0, s_bresp=0, s_rresp=0, s_rdata=0, AW/W/AR holding buffers empty, both FSMs idle, last_grant=READ (so the first contention goes to the write).
- Readies are 0 while in reset.
- Any transaction in flight when reset asserts is dropped with no response.

Address decode
- Byte address bits [1:0] are ignored.
- Word index = addr[P_ADDR_WIDTH-1:2]; err = (index >= P_NUM_REGS).

Write FSM: W_IDLE -> W_PEND -> W_RESP -> W_IDLE
- s_awready=1 while the AW buffer is empty and state != W_RESP; s_wready likewise for the W buffer.
- AW and W may arrive in either order or in the same cycle; each is captured on its handshake.
- Transition to W_PEND on the cycle after both buffers are full.
- In W_PEND:
  - if err: no strobe, go to W_RESP with bresp=2'b10 (SLVERR), same latency as a granted access;
  - else: request the arbiter; on grant, reg_wr_en=1 for that cycle with reg_addr/reg_wdata/reg_wstrb from the buffers, then go to W_RESP with bresp=2'b00.
- W_RESP: s_bvalid=1 until s_bready; on the handshake, clear both buffers and go to W_IDLE.
- Uncontested latency: AW+W handshake at cycle 0 -> reg_wr_en at cycle 1 -> s_bvalid at cycle 2.

Read FSM: R_IDLE -> R_PEND -> R_WAIT -> R_RESP -> R_IDLE
- s_arready=1 only in R_IDLE; capture the address on the handshake.
- R_PEND:
  - if err: skip the strobe, go to R_WAIT, then load s_rdata=0 and rresp=SLVERR;
  - else: on grant, reg_rd_en=1 with reg_addr, then go to R_WAIT.
- R_WAIT: register reg_rdata into s_rdata, rresp=OKAY.
- R_RESP: s_rvalid=1 until s_rready; s_rdata/s_rresp are held stable while stalled.
- Uncontested latency: AR handshake at cycle 0 -> reg_rd_en at cycle 1 -> s_rvalid at cycle 3.

Arbiter
- Requesters: W_PEND with !err, R_PEND with !err.
- One grant only; reg_wr_en and reg_rd_en are never high in the same cycle.
- On contention, grant the requester that is not last_grant. last_grant updates on every grant.
- The loser stays in PEND and is granted the next cycle.
- reg_addr is muxed by the grant; when idle it holds its last value.

Independence
- Write and read paths otherwise proceed concurrently.
- Backpressure on B or R stalls only that path.

Decomposition:
- Package base_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - write-FSM and read-FSM state encodings;
  - GRANT_WRITE/GRANT_READ constants.
- Sub-module rr_arb2: 2-requester round-robin arbiter, combinational grant plus a registered last_grant.

Test Plan:
1. Single write: AW+W same cycle, addr 0x08, data 0xA5A5_0001, wstrb 0xF -> reg_wr_en at cycle 1 with reg_addr=2; bvalid at cycle 2, bresp=OKAY.
2. W before AW by 3 cycles, addr 0x0C -> no strobe until AW arrives; then strobe 1 cycle later with reg_addr=3; wready=0 while W is buffered.
3. Contention: write to 0x04 and read from 0x10 reach PEND in the same cycle after reset -> reg_wr_en first, reg_rd_en the next cycle. Repeat -> read wins the second contention.
4. Out-of-range: read 0x40 with P_NUM_REGS=16 -> no reg_rd_en; rvalid with rresp=SLVERR, rdata=0. Write 0x44 -> no reg_wr_en; bresp=SLVERR.
5. Backpressure: bready=0 for 5 cycles -> bvalid held, awready/wready=0, a concurrent read to 0x00 completes with reg_rdata=0x1234 returned.
6. Reset mid-operation: assert ARESETN=0 while in R_RESP with rvalid=1 -> rvalid drops without waiting for a clock. After release: arready=1, a new read completes normally.

Source files
------------

// File: rtl/axil_reg_sequencer_pkg.sv
// Shared constants for the AXI4-Lite register sequencer.
// Response codes, FSM encodings and arbiter grant ids.
package base_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_PEND = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_PEND = 2'd1;
  localparam logic [1:0] R_WAIT = 2'd2;
  localparam logic [1:0] R_RESP = 2'd3;

  localparam logic GRANT_WRITE = 1'b0;
  localparam logic GRANT_READ  = 1'b1;

  function automatic logic idx_err(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx >= n);
  endfunction

endpackage

// File: rtl/axil_reg_sequencer_rr_arb2.sv
// Two-requester round-robin arbiter.
// Combinational grant, registered last winner.
module rr_arb2
  import base_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_w,
  input  logic req_r,
  output logic gnt_w,
  output logic gnt_r
);

  logic last_grant;

  // On contention the side that did not win last time goes first.
  always_comb begin
    gnt_w = req_w & (~req_r | (last_grant == GRANT_READ));
    gnt_r = req_r & (~req_w | (last_grant == GRANT_WRITE));
  end

  // Remember the most recent winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_READ;
    end else if (gnt_w) begin
      last_grant <= GRANT_WRITE;
    end else if (gnt_r) begin
      last_grant <= GRANT_READ;
    end
  end

endmodule

// File: rtl/axil_reg_sequencer.sv
// AXI4-Lite slave front-end that serialises writes and reads
// onto a single-port register bank.
module axil_reg_sequencer
  import base_pkg::*;
#(
  parameter int P_ADDR_WIDTH = 8,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_NUM_REGS   = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [P_ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [2:0]                s_awprot,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  input  logic [P_DATA_WIDTH-1:0]   s_wdata,
  input  logic [P_DATA_WIDTH/8-1:0] s_wstrb,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  output logic [1:0]                s_bresp,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  input  logic [P_ADDR_WIDTH-1:0]   s_araddr,
  input  logic [2:0]                s_arprot,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic [P_DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      reg_wr_en,
  output logic                      reg_rd_en,
  output logic [P_ADDR_WIDTH-3:0]   reg_addr,
  output logic [P_DATA_WIDTH-1:0]   reg_wdata,
  output logic [P_DATA_WIDTH/8-1:0] reg_wstrb,
  input  logic [P_DATA_WIDTH-1:0]   reg_rdata
);

  localparam int IW = P_ADDR_WIDTH - 2;

  logic [1:0]                w_state;
  logic [1:0]                r_state;
  logic                      aw_full;
  logic                      w_full;
  logic [IW-1:0]             aw_idx;
  logic [IW-1:0]             ar_idx;
  logic [IW-1:0]             addr_q;
  logic [P_DATA_WIDTH-1:0]   w_data;
  logic [P_DATA_WIDTH/8-1:0] w_strb;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      b_hs;
  logic                      ar_hs;
  logic                      w_err;
  logic                      r_err;
  logic                      req_w;
  logic                      req_r;
  logic                      gnt_w;
  logic                      gnt_r;
  logic                      unused_ok;

  assign unused_ok = ^{s_awprot, s_arprot,
                       s_awaddr[1:0], s_araddr[1:0]};

  // Handshakes, decode and arbiter requests.
  always_comb begin
    s_awready = ARESETN & ~aw_full & (w_state != W_RESP);
    s_wready  = ARESETN & ~w_full & (w_state != W_RESP);
    s_arready = ARESETN & (r_state == R_IDLE);
    s_bvalid  = (w_state == W_RESP);
    s_rvalid  = (r_state == R_RESP);
    aw_hs     = s_awvalid & s_awready;
    w_hs      = s_wvalid & s_wready;
    b_hs      = s_bvalid & s_bready;
    ar_hs     = s_arvalid & s_arready;
    w_err     = idx_err(32'(aw_idx), 32'(P_NUM_REGS));
    r_err     = idx_err(32'(ar_idx), 32'(P_NUM_REGS));
    req_w     = (w_state == W_PEND) & ~w_err;
    req_r     = (r_state == R_PEND) & ~r_err;
  end

  rr_arb2 u_arb (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .req_w (req_w),
    .req_r (req_r),
    .gnt_w (gnt_w),
    .gnt_r (gnt_r)
  );

  // Bank strobes follow the grant; address holds when idle.
  always_comb begin
    reg_wr_en = gnt_w;
    reg_rd_en = gnt_r;
    reg_wdata = w_data;
    reg_wstrb = w_strb;
    reg_addr  = addr_q;
    unique case (1'b1)
      gnt_w:   reg_addr = aw_idx;
      gnt_r:   reg_addr = ar_idx;
      default: reg_addr = addr_q;
    endcase
  end

  // Last driven bank address.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      addr_q <= '0;
    end else if (gnt_w) begin
      addr_q <= aw_idx;
    end else if (gnt_r) begin
      addr_q <= ar_idx;
    end
  end

  // AW and W holding buffers, emptied by the B handshake.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= s_awaddr[P_ADDR_WIDTH-1:2];
      end else if (b_hs) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end else if (b_hs) begin
        w_full <= 1'b0;
      end
    end
  end

  // Write FSM; leaves idle as soon as both halves are held.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      s_bresp <= RESP_OKAY;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if ((aw_full | aw_hs) & (w_full | w_hs))
            w_state <= W_PEND;
        end
        W_PEND: begin
          if (w_err) begin
            w_state <= W_RESP;
            s_bresp <= RESP_SLVERR;
          end else if (gnt_w) begin
            w_state <= W_RESP;
            s_bresp <= RESP_OKAY;
          end
        end
        W_RESP: begin
          if (s_bready)
            w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM; bank data lands one cycle after the strobe.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= R_IDLE;
      ar_idx  <= '0;
      s_rdata <= '0;
      s_rresp <= RESP_OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            ar_idx  <= s_araddr[P_ADDR_WIDTH-1:2];
            r_state <= R_PEND;
          end
        end
        R_PEND: begin
          if (r_err | gnt_r)
            r_state <= R_WAIT;
        end
        R_WAIT: begin
          s_rdata <= r_err ? '0 : reg_rdata;
          s_rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
          r_state <= R_RESP;
        end
        R_RESP: begin
          if (s_rready)
            r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_sequencer.sv
// Directed bench for axil_reg_sequencer with a bank model
// and response scoreboards.
module tb_axil_reg_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        s_awvalid, s_awready;
  logic [7:0]  s_awaddr;
  logic [2:0]  s_awprot;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [7:0]  s_araddr;
  logic [2:0]  s_arprot;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        reg_wr_en, reg_rd_en;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic [31:0] reg_rdata;

  int checks = 0;
  int errors = 0;

  logic [41:0] q_wr[$];
  logic [5:0]  q_rd[$];
  logic [1:0]  q_b[$];
  logic [33:0] q_r[$];
  logic [31:0] mem[64];

  always #5 ACLK = ~ACLK;

  axil_reg_sequencer dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rresp(s_rresp),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_rdata(reg_rdata)
  );

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Register bank model
  always @(posedge ACLK) begin
    if (reg_rd_en) reg_rdata <= mem[reg_addr];
    if (reg_wr_en)
      for (int b = 0; b < 4; b++)
        if (reg_wstrb[b])
          mem[reg_addr][8*b +: 8] = reg_wdata[8*b +: 8];
  end

  // Scoreboard: pop on every strobe and response beat
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (reg_wr_en) begin
        chk("wr_rd_excl", reg_rd_en, 0);
        chk("wr_expected", q_wr.size() != 0, 1);
        if (q_wr.size() != 0)
          chk("wr_strobe", {reg_addr, reg_wdata, reg_wstrb},
              q_wr.pop_front());
      end
      if (reg_rd_en) begin
        chk("rd_expected", q_rd.size() != 0, 1);
        if (q_rd.size() != 0)
          chk("rd_strobe", reg_addr, q_rd.pop_front());
      end
      if (s_bvalid && s_bready) begin
        chk("b_expected", q_b.size() != 0, 1);
        if (q_b.size() != 0)
          chk("b_resp", s_bresp, q_b.pop_front());
      end
      if (s_rvalid && s_rready) begin
        chk("r_expected", q_r.size() != 0, 1);
        if (q_r.size() != 0)
          chk("r_beat", {s_rresp, s_rdata}, q_r.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_q();
    q_wr.delete(); q_rd.delete();
    q_b.delete();  q_r.delete();
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    clear_q();
    step(); step();
    ARESETN = 1'b1;
    step();
  endtask

  // Drive AW and W together; expectation follows from the address.
  task automatic wr(logic [7:0] a, logic [31:0] d,
                    logic [3:0] s);
    s_awvalid = 1; s_awaddr = a;
    s_wvalid  = 1; s_wdata  = d; s_wstrb = s;
    if (a[7:2] < 16) begin
      q_wr.push_back({a[7:2], d, s});
      q_b.push_back(2'b00);
    end else begin
      q_b.push_back(2'b10);
    end
  endtask

  task automatic rd(logic [7:0] a);
    s_arvalid = 1; s_araddr = a;
    if (a[7:2] < 16) begin
      q_rd.push_back(a[7:2]);
      q_r.push_back({2'b00, mem[a[7:2]]});
    end else begin
      q_r.push_back({2'b10, 32'h0});
    end
  endtask

  task automatic idle_in();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 50; i++) begin
      if (q_wr.size() + q_rd.size() + q_b.size()
          + q_r.size() == 0) break;
      step();
    end
    chk(tag, q_wr.size() + q_rd.size() + q_b.size()
        + q_r.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i;
    ARESETN = 0; idle_in();
    s_awaddr = 0; s_awprot = 0; s_wdata = 0; s_wstrb = 0;
    s_araddr = 0; s_arprot = 0; s_bready = 1; s_rready = 1;
    #3;
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_awready", s_awready, 0);
    chk("rst_strobes", {reg_wr_en, reg_rd_en}, 0);
    chk("rst_rdata", {s_rresp, s_bresp, s_rdata}, 0);
    step();
    ARESETN = 1;
    step();
    chk("idle_readies", {s_awready, s_wready, s_arready}, 3'b111);

    // 1: single write, AW and W together
    wr(8'h08, 32'hA5A5_0001, 4'hF);
    step(); idle_in();
    chk("t1_wr_en", reg_wr_en, 1);
    chk("t1_addr", reg_addr, 2);
    step();
    chk("t1_bvalid", {s_bvalid, s_bresp}, 3'b100);
    drain("t1_drain");

    // 2: W leads AW by three cycles
    s_wvalid = 1; s_wdata = 32'h0000_BEEF; s_wstrb = 4'h3;
    q_wr.push_back({6'd3, 32'h0000_BEEF, 4'h3});
    q_b.push_back(2'b00);
    step(); s_wvalid = 0;
    chk("t2_wready_held", s_wready, 0);
    chk("t2_no_strobe", reg_wr_en, 0);
    step();
    chk("t2_no_strobe2", reg_wr_en, 0);
    step();
    s_awvalid = 1; s_awaddr = 8'h0C;
    step(); s_awvalid = 0;
    chk("t2_wr_en", {reg_wr_en, reg_addr}, {1'b1, 6'd3});
    drain("t2_drain");

    // 3: contention after reset, write wins then read wins
    do_reset();
    wr(8'h04, 32'h1111_2222, 4'hF); rd(8'h10);
    step(); idle_in();
    chk("t3a_first", {reg_wr_en, reg_rd_en}, 2'b10);
    step();
    chk("t3a_second", {reg_wr_en, reg_rd_en}, 2'b01);
    drain("t3a_drain");
    wr(8'h14, 32'h5555_6666, 4'hF);
    step(); idle_in();
    drain("t3_solo_drain");
    wr(8'h18, 32'h7777_8888, 4'hF); rd(8'h1C);
    step(); idle_in();
    chk("t3b_first", {reg_wr_en, reg_rd_en}, 2'b01);
    step();
    chk("t3b_second", {reg_wr_en, reg_rd_en}, 2'b10);
    drain("t3b_drain");

    // 4: out-of-range read and write
    rd(8'h40);
    step(); idle_in();
    chk("t4_no_rd", reg_rd_en, 0);
    step(); step();
    chk("t4_rvalid", {s_rvalid, s_rresp}, 3'b110);
    drain("t4r_drain");
    wr(8'h44, 32'hDEAD_BEEF, 4'hF);
    step(); idle_in();
    chk("t4_no_wr", reg_wr_en, 0);
    step();
    chk("t4_bvalid", {s_bvalid, s_bresp}, 3'b110);
    drain("t4w_drain");

    // 5: B backpressure while a read proceeds
    wr(8'h00, 32'h0000_1234, 4'hF);
    step(); idle_in();
    drain("t5_prep");
    s_bready = 0;
    wr(8'h20, 32'h0BAD_F00D, 4'hF);
    step(); idle_in();
    step();
    s_arvalid = 1; s_araddr = 8'h00;
    q_rd.push_back(6'd0);
    q_r.push_back({2'b00, 32'h0000_1234});
    for (int i = 0; i < 5; i++) begin
      chk("t5_bvalid", s_bvalid, 1);
      chk("t5_readies", {s_awready, s_wready}, 2'b00);
      step(); s_arvalid = 0;
    end
    chk("t5_read_done", q_r.size(), 0);
    s_bready = 1;
    drain("t5_drain");

    // 6: reset while R is stalled
    s_rready = 0;
    rd(8'h04);
    step(); idle_in();
    step(); step();
    chk("t6_rvalid", s_rvalid, 1);
    #2 ARESETN = 0;
    #1;
    chk("t6_rvalid_drop", s_rvalid, 0);
    chk("t6_arready_rst", s_arready, 0);
    clear_q();
    step(); step();
    ARESETN = 1; s_rready = 1;
    step();
    chk("t6_arready", s_arready, 1);
    rd(8'h08);
    step(); idle_in();
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
